nes_tetris_soc_usb_ctl_out: RTL
===============================

Name: nes_tetris_soc_usb_ctl_out

Overview:
- Avalon-MM slave output PIO. It drives the USB controller's control pins (e.g. MAX3421E reset and SS override) from the Nios II.
- It is the write/drive-side counterpart of the read-only GPX input PIO and sits on the same system interconnect.
- Besides a plain data register, it provides a hardware-timed pulse engine. This lets firmware issue exact-width reset pulses without busy-waiting.
- An optional interrupt signals when a pulse completes.

Parameters:
- WIDTH, 2, number of output pins (1..32)
- RESET_VALUE, 0, value of the data register after reset (WIDTH bits)
- PULSE_W, 16, width of the pulse-length counter (1..31)
- DEFAULT_LEN, 50000, pulse length after reset, in clk cycles

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  pulse-done interrupt, level, active-high
- out_port  out  WIDTH  driven pins

Behaviour:
- Register map (word address):
  - 0 DATA: R/W. Write stores writedata[WIDTH-1:0] into data_reg. Read returns out_port.
  - 1 PULSE: W starts a pulse with mask = writedata[WIDTH-1:0]. Read returns pulse_mask zero-extended.
  - 2 LEN: R/W. Write stores writedata[PULSE_W-1:0] into len_reg. Read returns len_reg zero-extended.
  - 3 STATUS: read returns bit0=busy, bit1=done, bit2=irq_en, other bits 0. Write: bit2 sets irq_en; bit1=1 clears done; bit0=1 aborts an active pulse.
- out_port = data_reg XOR (busy ? pulse_mask : 0). The output is registered, so out_port changes one cycle after the causing write or count edge. There is no combinational path from the bus to the pins.
- Pulse engine states:
  - IDLE: busy=0. A write to PULSE with nonzero mask and len_reg≠0 loads count=len_reg and latches pulse_mask, then goes to ACTIVE.
  - ACTIVE: busy=1 and count decrements each cycle. The selected pins stay inverted for exactly len_reg cycles. When count reaches 1 and decrements to 0, the engine sets done=1 and returns to IDLE.
- A PULSE write with mask=0 or len_reg=0 performs no pulse. pulse_mask still updates; busy and done are unchanged.
- A PULSE write while ACTIVE is ignored entirely (no retrigger, mask not changed).
- A LEN write while ACTIVE updates len_reg only; the running count is unaffected.
- A DATA write while ACTIVE updates data_reg immediately. Inversion of masked bits continues relative to the new data_reg.
- Abort (STATUS write with bit0=1) while ACTIVE: return to IDLE next cycle, count=0, and done is NOT set. Abort in IDLE has no effect.
- If done is being set and cleared by a STATUS write in the same cycle, set wins.
- irq = done AND irq_en.
- readdata: registered every cycle from the address mux, regardless of chipselect. Read latency is 1 cycle. Reads have no side effects.
- Reset values: data_reg=RESET_VALUE, out_port=RESET_VALUE, pulse_mask=0, len_reg=DEFAULT_LEN, count=0, busy=0, done=0, irq_en=0, irq=0, readdata=0.
- Reset mid-pulse terminates the pulse. out_port returns to RESET_VALUE on the cycle after reset is sampled high.
- Width rules:
  - writedata bits above WIDTH (data/mask) or PULSE_W (len) are ignored.
  - The count never wraps. It is only loaded from nonzero len_reg and stops at 0.

Test Plan:
- Reset, then read addresses 0..3 -> readdata 0, 0, DEFAULT_LEN (50000), 0; out_port=0; irq=0.
- Write DATA=0x3, then read DATA -> out_port=0x3 one cycle after the write; readdata=0x3 one cycle after the address.
- Write LEN=5, then PULSE=0x1 with data_reg=0 -> out_port=0x1 for exactly 5 cycles, then 0x0. busy=1 during the pulse, done=1 afterwards. irq stays 0 because irq_en=0.
- Write STATUS=0x4, run a LEN=3 pulse, then write STATUS=0x2 -> irq rises when the pulse ends and falls one cycle after the clear write. A second PULSE write mid-pulse does not extend it (still 3 cycles).
- Start a LEN=100 pulse, write STATUS=0x1 at cycle 10 -> out_port restored next cycle, busy=0, done=0, irq=0. A PULSE write with LEN=0 -> no pulse, busy stays 0.
- Start a LEN=100 pulse on mask 0x2, assert reset at cycle 20 -> out_port=RESET_VALUE and busy=0 after reset. After release, LEN reads back 50000.

Source files
------------

// File: rtl/nes_tetris_soc_usb_ctl_out.sv
// Avalon-MM output PIO for the USB controller control pins.
// It has a plain data register and a hardware-timed pulse engine, so firmware
// can produce exact-width reset pulses without polling. An optional interrupt
// is raised when a pulse completes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no pulse running; out_port follows data_reg
// S_ACTIVE | pulse running; masked pins inverted while count runs down
module nes_tetris_soc_usb_ctl_out #(
  parameter int               WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PULSE_W     = 16,
  parameter int               DEFAULT_LEN = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_PULSE  = 2'd1;
  localparam logic [1:0] A_LEN    = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   data_reg, data_nxt;
  logic [WIDTH-1:0]   pulse_mask, mask_nxt;
  logic [PULSE_W-1:0] len_reg, len_nxt;
  logic [PULSE_W-1:0] count, count_nxt;
  logic               done, done_nxt;
  logic               irq_en, irq_en_nxt;
  logic [WIDTH-1:0]   out_nxt;
  logic [31:0]        rd_nxt;
  logic               wr;
  logic               done_set;
  logic               busy;
  logic               unused_wd;

  // Only the low WIDTH / PULSE_W bits and STATUS bits 2:0 are meaningful.
  assign unused_wd = ^writedata;

  assign wr   = chipselect & ~write_n;
  assign busy = (state == S_ACTIVE);
  assign irq  = done & irq_en;

  // Next-state for the pulse engine and the register file, plus the read mux.
  always_comb begin
    state_nxt  = state;
    data_nxt   = data_reg;
    mask_nxt   = pulse_mask;
    len_nxt    = len_reg;
    count_nxt  = count;
    done_nxt   = done;
    irq_en_nxt = irq_en;
    done_set   = 1'b0;
    out_nxt    = '0;
    rd_nxt     = '0;

    case (state)
      S_IDLE: begin
        if (wr && address == A_PULSE) begin
          mask_nxt = writedata[WIDTH-1:0];
          if (writedata[WIDTH-1:0] != '0 && len_reg != '0) begin
            count_nxt = len_reg;
            state_nxt = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        // Abort takes priority over a completion landing on the same edge.
        if (wr && address == A_STATUS && writedata[0]) begin
          count_nxt = '0;
          state_nxt = S_IDLE;
        end else if (count <= PULSE_W'(1)) begin
          count_nxt = '0;
          state_nxt = S_IDLE;
          done_set  = 1'b1;
        end else begin
          count_nxt = count - PULSE_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (wr && address == A_DATA) data_nxt = writedata[WIDTH-1:0];
    if (wr && address == A_LEN)  len_nxt  = writedata[PULSE_W-1:0];
    if (wr && address == A_STATUS) begin
      irq_en_nxt = writedata[2];
      if (writedata[1]) done_nxt = 1'b0;
    end
    // Completion beats a simultaneous clear so a pulse end is never lost.
    if (done_set) done_nxt = 1'b1;

    out_nxt = data_nxt ^ ((state_nxt == S_ACTIVE) ? mask_nxt : '0);

    case (address)
      A_DATA:   rd_nxt[WIDTH-1:0]   = out_port;
      A_PULSE:  rd_nxt[WIDTH-1:0]   = pulse_mask;
      A_LEN:    rd_nxt[PULSE_W-1:0] = len_reg;
      A_STATUS: rd_nxt[2:0]         = {irq_en, done, busy};
      default:  rd_nxt              = '0;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      data_reg   <= RESET_VALUE;
      pulse_mask <= '0;
      len_reg    <= PULSE_W'(DEFAULT_LEN);
      count      <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      out_port   <= RESET_VALUE;
      readdata   <= '0;
    end else begin
      state      <= state_nxt;
      data_reg   <= data_nxt;
      pulse_mask <= mask_nxt;
      len_reg    <= len_nxt;
      count      <= count_nxt;
      done       <= done_nxt;
      irq_en     <= irq_en_nxt;
      out_port   <= out_nxt;
      readdata   <= rd_nxt;
    end
  end

endmodule
